// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder backed by a word
// array, with WAIT_CYCLES wait states between acceptance and response.
// Optional address-range checking: define DMEM_ADDR_CHECK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;

    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_write;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [3:0]    w_acc_be;
    logic [AW-1:0] w_idx;
    logic          w_oob;
    logic          w_unused_addr;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Zero-wait transactions access the array on the acceptance edge itself,
    // so the live request is used there; otherwise the latched copy.
    assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? req_be    : r_be;

    assign w_idx         = w_acc_addr[AW+1:2];
    assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[31:AW+2]};

`ifdef DMEM_ADDR_CHECK_EN
    assign w_oob = (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    assign w_oob = 1'b0;
`endif

    assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_cnt   <= CW'(WAIT_CYCLES);
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Byte-lane store on the edge entering RESP; array is never reset
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_acc_write && !w_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data/error capture, held through RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_oob;
            r_rdata <= (w_acc_write || w_oob) ? 32'd0 : r_mem[w_idx];
        end
    end

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign rsp_valid = (r_state == S_RESP) && !reset;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: spec vectors, reset abort,
// zero-wait back-to-back traffic and randomized traffic against a word model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;
`ifdef DMEM_ADDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte address -> word slot, modulo the array depth
    function automatic logic m_oob(input logic [31:0] a);
        return CHK && ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] m_exp(input logic w, input logic [31:0] a);
        if (w || m_oob(a)) return 32'd0;
        return m_mem[m_idx(a)];
    endfunction

    task automatic m_apply(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        int idx;
        idx = m_idx(a);
        if (w && !m_oob(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_mem[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance, checked cycle by cycle
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit noise,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        @(negedge clk);
        chk({tag, " req_ready_busy"}, 32'(req_ready), 32'd0);
        if (noise) begin
            req_write = 1'b1;
            req_addr  = 32'($urandom_range(0, 31)) << 2;
            req_wdata = $urandom;
            req_be    = 4'hF;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(WAITC));
        for (int k = 0; k <= hold; k++) begin
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
            chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, " req_ready_resp"}, 32'(req_ready), 32'd0);
            if (k == hold) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " rsp_valid_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready_done"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        w;
        logic [31:0] a, wd, v;
        logic [3:0]  be;
        logic [31:0] zd [6];
        int          word;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_be = '0; z_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);
        chk("post-reset z_req_ready", 32'(z_req_ready), 32'd1);

        // Preload words 0..31 with known nonzero data
        for (int i = 0; i < 32; i++) begin
            v = $urandom | 32'h1;
            txn(1'b1, 32'(i) << 2, v, 4'hF, 0, 1'b0, 32'd0, 1'b0, "preload");
            m_apply(1'b1, 32'(i) << 2, v, 4'hF);
        end

        // Directed vectors
        vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 5, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h23,   32'h0,        4'h0, 1, 32'h11BB33DD, 1'b0};
        vt[6]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 32'h20,   32'h0,        4'h3, 0, 32'h11BB33DD, 1'b0};
        vt[8]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0};
        vt[9]  = '{1'b1, 32'h4,    32'h55667788, 4'hF, 0, 32'h0, 1'b0};
        vt[10] = '{1'b0, 32'h1000, 32'h0,        4'hF, 2, CHK ? 32'h0 : 32'hCAFEF00D, CHK};
        vt[11] = '{1'b1, 32'h1004, 32'h12345678, 4'hF, 0, 32'h0, CHK};
        vt[12] = '{1'b0, 32'h4,    32'h0,        4'hF, 0, CHK ? 32'h55667788 : 32'h12345678, 1'b0};
        vt[13] = '{1'b0, 32'h0,    32'h0,        4'hF, 0, 32'hCAFEF00D, 1'b0};
        for (int i = 0; i < 14; i++) begin
            txn(vt[i].w, vt[i].a, vt[i].wd, vt[i].be, vt[i].hold, 1'b0,
                vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
            m_apply(vt[i].w, vt[i].a, vt[i].wd, vt[i].be);
        end

        // Reset while a store to 0x40 waits: store must not land
        txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, m_exp(1'b0, 32'h40), 1'b0, "pre-abort load");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        req_wdata = 32'h0BADC0DE; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_rdata", rsp_rdata, 32'd0);
        chk("abort rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort post req_ready", 32'(req_ready), 32'd1);
        chk("abort post rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, m_exp(1'b0, 32'h40), 1'b0, "post-abort load");

        // Zero-wait instance: back-to-back, one transaction per two cycles
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) begin
                if (p == 0) zd[i] = $urandom;
                chk("z0 req_ready", 32'(z_req_ready), 32'd1);
                chk("z0 rsp_valid_idle", 32'(z_rsp_valid), 32'd0);
                z_req_valid = 1'b1;
                z_req_write = (p == 0);
                z_req_addr  = 32'(400 + i) << 2;
                z_req_wdata = zd[i];
                z_req_be    = 4'hF;
                @(negedge clk);
                chk("z0 rsp_valid", 32'(z_rsp_valid), 32'd1);
                chk("z0 rsp_rdata", z_rsp_rdata, (p == 0) ? 32'd0 : zd[i]);
                chk("z0 req_ready_resp", 32'(z_req_ready), 32'd0);
                @(negedge clk);
            end
        end
        z_req_valid = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 120; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) word = 1024 + $urandom_range(0, 31);
            else                           word = $urandom_range(0, 31);
            a  = (32'(word) << 2) | 32'($urandom_range(0, 3));
            be = 4'($urandom);
            wd = $urandom;
            txn(w, a, wd, be, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                m_exp(w, a), m_oob(a), $sformatf("rnd%0d", i));
            m_apply(w, a, wd, be);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
